// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if
//   Bundles the SPI shifter strobes and the internal register-bus signals handled by
//   spi_reg_ctrl.
//   master : controller side   -- drives spi_tx_byte, reg_addr, reg_wdata, reg_we, reg_re,
//                                 busy, frame_done
//   slave  : shifter/regfile   -- drives spi_ss, spi_rx, spi_rx_byte, spi_tx, reg_rdata
interface spi_reg_ctrl_if #(
   parameter int unsigned AW = 7
);
   logic          spi_ss;
   logic          spi_rx;
   logic [7:0]    spi_rx_byte;
   logic          spi_tx;
   logic [7:0]    spi_tx_byte;
   logic [AW-1:0] reg_addr;
   logic [7:0]    reg_wdata;
   logic          reg_we;
   logic          reg_re;
   logic [7:0]    reg_rdata;
   logic          busy;
   logic          frame_done;

   modport master (
      input  spi_ss, spi_rx, spi_rx_byte, spi_tx, reg_rdata,
      output spi_tx_byte, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_done
   );

   modport slave (
      output spi_ss, spi_rx, spi_rx_byte, spi_tx, reg_rdata,
      input  spi_tx_byte, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_done
   );
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
//   Byte-level transaction controller between an SPI slave shifter and the internal register
//   bus. The first byte of a frame is a command {rw, addr}; following bytes are data. Writes
//   are committed as one reg_we pulse per received byte; reads are prefetched with one reg_re
//   pulse per byte so the next outgoing byte is ready before the shifter loads it.
//
//   Ports
//     clk   : system clock
//     rst   : asynchronous active-high reset
//     ena   : global clock enable; when low all state holds and strobes are ignored
//     bus   : spi_reg_ctrl_if.master
//               spi_ss/spi_rx/spi_rx_byte/spi_tx from the shifter, spi_tx_byte to it,
//               reg_addr/reg_wdata/reg_we/reg_re/reg_rdata register bus,
//               busy (not idle) and frame_done (one-cycle pulse at deselect)
//
//   Build option
//     SPI_REG_CTRL_AUTOINC_EN : when defined, the address increments (mod 2^AW) after every
//                               data byte; otherwise it stays at the command address.
module spi_reg_ctrl #(
   parameter int unsigned AW        = 7,
   parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ena,
   spi_reg_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StWr,
      StRdReq,
      StRd
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] addr_next;
   logic [AW-1:0] rx_addr;

   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          pend_vld_q, pend_vld_d;
   logic [7:0]    pend_byte_q, pend_byte_d;
   logic          tx_upd;
   logic [7:0]    tx_val;

   logic [AW-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]    reg_wdata_q, reg_wdata_d;
   logic          reg_we_q, reg_we_d;
   logic          reg_re_q, reg_re_d;
   logic          busy_q;
   logic          frame_done_q, frame_done_d;
   // High in the cycle after reg_re, i.e. when reg_rdata is valid.
   logic          cap_q;

   assign rx_addr = bus.spi_rx_byte[AW-1:0];

`ifdef SPI_REG_CTRL_AUTOINC_EN
   // AW-bit add wraps naturally from 2^AW-1 to 0.
   assign addr_next = addr_q + AW'(1);
`else
   assign addr_next = addr_q;
`endif

   //--------------------------------------------------------------------------------------
   // FSM next state and register-bus pulses
   //--------------------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      reg_addr_d   = reg_addr_q;
      reg_wdata_d  = reg_wdata_q;
      reg_we_d     = 1'b0;
      reg_re_d     = 1'b0;
      frame_done_d = 1'b0;
      tx_upd       = 1'b0;
      tx_val       = tx_byte_q;

      if (ena) begin
         unique case (state_q)
            StIdle: begin
               if (!bus.spi_ss) begin
                  state_d = StCmd;
                  tx_upd  = 1'b1;
                  tx_val  = IDLE_BYTE;
               end
            end

            StCmd: begin
               if (bus.spi_rx) begin
                  addr_d = rx_addr;
                  if (bus.spi_rx_byte[7]) begin
                     // Issue the first prefetch straight away so reg_re lands one cycle
                     // after the command byte.
                     state_d    = StRdReq;
                     reg_re_d   = 1'b1;
                     reg_addr_d = rx_addr;
                  end else begin
                     state_d = StWr;
                  end
               end
            end

            StWr: begin
               if (bus.spi_rx) begin
                  reg_we_d    = 1'b1;
                  reg_addr_d  = addr_q;
                  reg_wdata_d = bus.spi_rx_byte;
                  addr_d      = addr_next;
               end
            end

            StRdReq: begin
               // reg_re is high during this state; data arrives next cycle in StRd.
               state_d = StRd;
            end

            StRd: begin
               if (cap_q) begin
                  tx_upd = 1'b1;
                  tx_val = bus.reg_rdata;
               end
               if (bus.spi_rx) begin
                  addr_d     = addr_next;
                  reg_re_d   = 1'b1;
                  reg_addr_d = addr_next;
                  state_d    = StRdReq;
               end
            end

            default: state_d = StIdle;
         endcase

         // Deselect wins over everything except pulses already decided above: a byte that
         // completed in this same cycle is still committed/issued.
         if (state_q != StIdle && bus.spi_ss) begin
            state_d      = StIdle;
            frame_done_d = 1'b1;
            tx_upd       = 1'b1;
            tx_val       = IDLE_BYTE;
         end
      end
   end

   //--------------------------------------------------------------------------------------
   // Outgoing byte: never changes in a cycle where the shifter is loading it. A clashing
   // update is parked for one cycle (spi_tx is a single-cycle strobe).
   //--------------------------------------------------------------------------------------
   always_comb begin
      tx_byte_d   = tx_byte_q;
      pend_vld_d  = pend_vld_q;
      pend_byte_d = pend_byte_q;

      if (ena) begin
         if (bus.spi_tx) begin
            if (tx_upd) begin
               pend_vld_d  = 1'b1;
               pend_byte_d = tx_val;
            end
         end else if (tx_upd) begin
            tx_byte_d  = tx_val;
            pend_vld_d = 1'b0;
         end else if (pend_vld_q) begin
            tx_byte_d  = pend_byte_q;
            pend_vld_d = 1'b0;
         end
      end
   end

   //--------------------------------------------------------------------------------------
   // State registers
   //--------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         tx_byte_q    <= IDLE_BYTE;
         pend_vld_q   <= 1'b0;
         pend_byte_q  <= IDLE_BYTE;
         reg_addr_q   <= '0;
         reg_wdata_q  <= 8'h00;
         reg_we_q     <= 1'b0;
         reg_re_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cap_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         tx_byte_q    <= tx_byte_d;
         pend_vld_q   <= pend_vld_d;
         pend_byte_q  <= pend_byte_d;
         reg_addr_q   <= reg_addr_d;
         reg_wdata_q  <= reg_wdata_d;
         // Pulses always fall back to zero so they stay single-cycle even if ena drops.
         reg_we_q     <= reg_we_d;
         reg_re_q     <= reg_re_d;
         busy_q       <= (state_d != StIdle);
         frame_done_q <= frame_done_d;
         cap_q        <= reg_re_q;
      end
   end

   assign bus.spi_tx_byte = tx_byte_q;
   assign bus.reg_addr    = reg_addr_q;
   assign bus.reg_wdata   = reg_wdata_q;
   assign bus.reg_we      = reg_we_q;
   assign bus.reg_re      = reg_re_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl
//   Directed bench for spi_reg_ctrl. A byte-level shifter stand-in produces spi_tx/spi_rx
//   strobes with an SPI half-period of H clk cycles; a register model answers reads with
//   addr ^ 8'h5A one cycle after reg_re.
module tb_spi_reg_ctrl;
   localparam int H = 4;

`ifdef SPI_REG_CTRL_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ena = 1'b1;

   spi_reg_ctrl_if #(.AW(7)) bus ();

   spi_reg_ctrl #(.AW(7), .IDLE_BYTE(8'hFF)) dut (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Register model: data valid in the cycle after reg_re, zero otherwise.
   always @(posedge clk) bus.reg_rdata <= bus.reg_re ? ({1'b0, bus.reg_addr} ^ 8'h5A) : 8'h00;

   // Bus activity log, sampled on the inactive edge.
   logic [14:0] wr_log[$];
   logic [6:0]  rd_log[$];
   int          fd_cnt = 0;
   always @(negedge clk) begin
      if (bus.reg_we) wr_log.push_back({bus.reg_addr, bus.reg_wdata});
      if (bus.reg_re) rd_log.push_back(bus.reg_addr);
      if (bus.frame_done) fd_cnt++;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One byte: load (spi_tx) then, one half-period before the next load, receive (spi_rx).
   task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
      bus.spi_tx = 1'b1;
      miso = bus.spi_tx_byte;
      step(1);
      bus.spi_tx = 1'b0;
      step(15 * H - 1);
      bus.spi_rx = 1'b1;
      bus.spi_rx_byte = mosi;
      step(1);
      bus.spi_rx = 1'b0;
      step(H - 1);
   endtask

   task automatic frame_start();
      bus.spi_ss = 1'b0;
      step(H);
   endtask

   task automatic frame_end();
      bus.spi_ss = 1'b1;
      step(3);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      n_cmp++; if (bus.spi_tx_byte !== 8'hFF) begin n_bad++;
         $display("FAIL reset_tx_byte: got %h want ff", bus.spi_tx_byte); end
      n_cmp++; if ({bus.reg_addr, bus.reg_wdata} !== 15'h0) begin n_bad++;
         $display("FAIL reset_addr_wdata: got %h/%h want 0/0", bus.reg_addr, bus.reg_wdata); end
      n_cmp++; if ({bus.reg_we, bus.reg_re} !== 2'b00) begin n_bad++;
         $display("FAIL reset_we_re: got %b%b want 00", bus.reg_we, bus.reg_re); end
      n_cmp++; if ({bus.busy, bus.frame_done} !== 2'b00) begin n_bad++;
         $display("FAIL reset_busy_fd: got %b%b want 00", bus.busy, bus.frame_done); end
      rst = 1'b0;
      step(2);
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++;
         $display("FAIL idle_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_write_burst();
      logic [7:0] m0, m1, m2;
      int wb = wr_log.size();
      int fb = fd_cnt;
      frame_start();
      xfer(8'h05, m0);
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++;
         $display("FAIL wr_busy: got %b want 1", bus.busy); end
      xfer(8'h11, m1);
      xfer(8'h22, m2);
      frame_end();
      n_cmp++; if ({m0, m1, m2} !== 24'hFFFFFF) begin n_bad++;
         $display("FAIL wr_miso: got %h %h %h want ff ff ff", m0, m1, m2); end
      n_cmp++; if (wr_log.size() - wb !== 2) begin n_bad++;
         $display("FAIL wr_count: got %0d want 2", wr_log.size() - wb); end
      n_cmp++; if (wr_log[wb] !== {7'd5, 8'h11}) begin n_bad++;
         $display("FAIL wr_0: got %h want %h", wr_log[wb], {7'd5, 8'h11}); end
      n_cmp++; if (wr_log[wb+1] !== {(AUTOINC ? 7'd6 : 7'd5), 8'h22}) begin n_bad++;
         $display("FAIL wr_1: got %h want %h", wr_log[wb+1], {(AUTOINC ? 7'd6 : 7'd5), 8'h22}); end
      n_cmp++; if (fd_cnt - fb !== 1) begin n_bad++;
         $display("FAIL wr_frame_done: got %0d want 1", fd_cnt - fb); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++;
         $display("FAIL wr_busy_end: got %b want 0", bus.busy); end
   endtask

   task automatic test_read_burst();
      logic [7:0] m0, m1, m2;
      int rb = rd_log.size();
      int wb = wr_log.size();
      frame_start();
      xfer(8'h83, m0);
      xfer(8'h00, m1);
      xfer(8'h00, m2);
      frame_end();
      n_cmp++; if (m0 !== 8'hFF) begin n_bad++;
         $display("FAIL rd_miso0: got %h want ff", m0); end
      n_cmp++; if (m1 !== 8'h59) begin n_bad++;
         $display("FAIL rd_miso1: got %h want 59", m1); end
      n_cmp++; if (m2 !== (AUTOINC ? 8'h5E : 8'h59)) begin n_bad++;
         $display("FAIL rd_miso2: got %h want %h", m2, AUTOINC ? 8'h5E : 8'h59); end
      n_cmp++; if (rd_log.size() - rb !== 3) begin n_bad++;
         $display("FAIL rd_count: got %0d want 3", rd_log.size() - rb); end
      n_cmp++; if ({rd_log[rb], rd_log[rb+1], rd_log[rb+2]} !==
                   (AUTOINC ? {7'd3, 7'd4, 7'd5} : {7'd3, 7'd3, 7'd3})) begin n_bad++;
         $display("FAIL rd_addrs: got %0d %0d %0d", rd_log[rb], rd_log[rb+1], rd_log[rb+2]); end
      n_cmp++; if (wr_log.size() !== wb) begin n_bad++;
         $display("FAIL rd_no_write: got %0d writes want 0", wr_log.size() - wb); end
      n_cmp++; if (bus.spi_tx_byte !== 8'hFF) begin n_bad++;
         $display("FAIL rd_tx_idle: got %h want ff", bus.spi_tx_byte); end
   endtask

   task automatic test_wrap();
      logic [7:0] m;
      int wb = wr_log.size();
      frame_start();
      xfer(8'h7F, m);
      xfer(8'hA1, m);
      xfer(8'hA2, m);
      xfer(8'hA3, m);
      frame_end();
      n_cmp++; if (wr_log.size() - wb !== 3) begin n_bad++;
         $display("FAIL wrap_count: got %0d want 3", wr_log.size() - wb); end
      n_cmp++; if (wr_log[wb] !== {7'd127, 8'hA1}) begin n_bad++;
         $display("FAIL wrap_0: got %h want %h", wr_log[wb], {7'd127, 8'hA1}); end
      n_cmp++; if (wr_log[wb+1] !== {(AUTOINC ? 7'd0 : 7'd127), 8'hA2}) begin n_bad++;
         $display("FAIL wrap_1: got %h want %h", wr_log[wb+1], {(AUTOINC ? 7'd0 : 7'd127), 8'hA2}); end
      n_cmp++; if (wr_log[wb+2] !== {(AUTOINC ? 7'd1 : 7'd127), 8'hA3}) begin n_bad++;
         $display("FAIL wrap_2: got %h want %h", wr_log[wb+2], {(AUTOINC ? 7'd1 : 7'd127), 8'hA3}); end
   endtask

   task automatic test_abort();
      logic [7:0] m;
      int wb = wr_log.size();
      int rb = rd_log.size();
      int fb = fd_cnt;
      frame_start();
      xfer(8'h20, m);
      // Half a data byte: load, then four bits' worth of clocks.
      bus.spi_tx = 1'b1;
      step(1);
      bus.spi_tx = 1'b0;
      step(8 * H);
      bus.spi_ss = 1'b1;
      step(1);
      n_cmp++; if ({bus.frame_done, bus.busy} !== 2'b10) begin n_bad++;
         $display("FAIL abort_fd_busy: got %b%b want 10", bus.frame_done, bus.busy); end
      step(1);
      n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++;
         $display("FAIL abort_fd_once: got %b want 0", bus.frame_done); end
      // Deselect in CMD before any byte.
      frame_start();
      bus.spi_ss = 1'b1;
      step(1);
      n_cmp++; if (bus.frame_done !== 1'b1) begin n_bad++;
         $display("FAIL cmd_abort_fd: got %b want 1", bus.frame_done); end
      step(2);
      n_cmp++; if (fd_cnt - fb !== 2) begin n_bad++;
         $display("FAIL abort_fd_count: got %0d want 2", fd_cnt - fb); end
      n_cmp++; if ((wr_log.size() - wb) + (rd_log.size() - rb) !== 0) begin n_bad++;
         $display("FAIL abort_no_bus: got %0d pulses want 0",
                  (wr_log.size() - wb) + (rd_log.size() - rb)); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] m0, m1;
      int rb, fb;
      fb = fd_cnt;
      frame_start();
      xfer(8'h83, m0);
      step(5);
      n_cmp++; if (bus.spi_tx_byte !== 8'h59) begin n_bad++;
         $display("FAIL rst_pre_tx: got %h want 59", bus.spi_tx_byte); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.spi_tx_byte !== 8'hFF) begin n_bad++;
         $display("FAIL rst_mid_tx: got %h want ff", bus.spi_tx_byte); end
      n_cmp++; if ({bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, bus.busy,
                    bus.frame_done} !== 19'h0) begin n_bad++;
         $display("FAIL rst_mid_outs: got %h/%h/%b%b%b%b want all 0", bus.reg_addr,
                  bus.reg_wdata, bus.reg_we, bus.reg_re, bus.busy, bus.frame_done); end
      bus.spi_ss = 1'b1;
      step(2);
      rst = 1'b0;
      step(2);
      n_cmp++; if (fd_cnt !== fb) begin n_bad++;
         $display("FAIL rst_no_fd: got %0d want 0", fd_cnt - fb); end
      rb = rd_log.size();
      frame_start();
      xfer(8'h80, m0);
      xfer(8'h00, m1);
      frame_end();
      n_cmp++; if ({m0, m1} !== 16'hFF5A) begin n_bad++;
         $display("FAIL rst_after_read: got %h %h want ff 5a", m0, m1); end
      n_cmp++; if (rd_log[rb] !== 7'd0) begin n_bad++;
         $display("FAIL rst_after_addr: got %0d want 0", rd_log[rb]); end
   endtask

   task automatic test_ena();
      logic [7:0] m;
      int wb = wr_log.size();
      frame_start();
      xfer(8'h10, m);
      bus.spi_tx = 1'b1;
      step(1);
      bus.spi_tx = 1'b0;
      step(15 * H - 1);
      ena = 1'b0;
      bus.spi_rx = 1'b1;
      bus.spi_rx_byte = 8'hAA;
      step(1);
      bus.spi_rx = 1'b0;
      step(1);
      ena = 1'b1;
      step(H - 2);
      xfer(8'hBB, m);
      frame_end();
      n_cmp++; if (wr_log.size() - wb !== 1) begin n_bad++;
         $display("FAIL ena_count: got %0d want 1", wr_log.size() - wb); end
      n_cmp++; if (wr_log[wb] !== {7'h10, 8'hBB}) begin n_bad++;
         $display("FAIL ena_write: got %h want %h", wr_log[wb], {7'h10, 8'hBB}); end
   endtask

   // Read data arrives while the shifter is loading: the update must slip by one cycle.
   task automatic test_tx_defer();
      frame_start();
      bus.spi_tx = 1'b1;
      step(1);
      bus.spi_tx = 1'b0;
      step(15 * H - 1);
      bus.spi_rx = 1'b1;
      bus.spi_rx_byte = 8'h83;
      step(1);
      bus.spi_rx = 1'b0;
      step(1);
      bus.spi_tx = 1'b1;
      n_cmp++; if (bus.spi_tx_byte !== 8'hFF) begin n_bad++;
         $display("FAIL defer_t2: got %h want ff", bus.spi_tx_byte); end
      step(1);
      bus.spi_tx = 1'b0;
      n_cmp++; if (bus.spi_tx_byte !== 8'hFF) begin n_bad++;
         $display("FAIL defer_t3: got %h want ff", bus.spi_tx_byte); end
      step(1);
      n_cmp++; if (bus.spi_tx_byte !== 8'h59) begin n_bad++;
         $display("FAIL defer_t4: got %h want 59", bus.spi_tx_byte); end
      frame_end();
   endtask

   initial begin
      bus.spi_ss      = 1'b1;
      bus.spi_rx      = 1'b0;
      bus.spi_rx_byte = 8'h00;
      bus.spi_tx      = 1'b0;
      test_reset();
      test_write_burst();
      test_read_burst();
      test_wrap();
      test_abort();
      test_reset_mid();
      test_ena();
      test_tx_defer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Byte-level transaction controller placed between the SPI slave shifter and the internal register bus.
- Decodes a command byte {rw, addr[6:0]} and then streams data bytes. Writes are committed on each received byte; reads are prefetched so that every outgoing byte is loaded in time.
- Owns the shifter's bus_in byte and converts its rx/tx strobes into single-cycle register-bus read/write pulses with optional address auto-increment.

Parameters:
- AW, 7, register address width; the command byte carries addr in bits [AW-1:0], and AW ≤ 7.
- IDLE_BYTE, 8'hFF, byte returned on MISO during the command byte and during write bursts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ena  in  1  global clock enable; when low, all state holds and no strobes are acted on
- spi_ss  in  1  chip select from the pad, already synchronous to clk; high = deselected
- spi_rx  in  1  one-cycle strobe: a full byte is present on spi_rx_byte
- spi_rx_byte  in  8  received byte from the shifter
- spi_tx  in  1  one-cycle strobe: the shifter has just loaded spi_tx_byte
- spi_tx_byte  out  8  next byte to transmit (drives the shifter's bus_in)
- reg_addr  out  AW  register bus address
- reg_wdata  out  8  register bus write data
- reg_we  out  1  one-cycle write pulse
- reg_re  out  1  one-cycle read pulse
- reg_rdata  in  8  read data; valid in the cycle after reg_re
- busy  out  1  high while in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a transaction ends on the rising edge of spi_ss

Behaviour:
- Reset values: spi_tx_byte=IDLE_BYTE, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, frame_done=0, state=IDLE. Reset is valid mid-transaction: it discards everything and issues no pulses.
- All outputs are registered. All transitions are qualified by ena.
- FSM states: IDLE, CMD, WR, RD_REQ, RD.
- IDLE: spi_ss=0 -> CMD, with spi_tx_byte=IDLE_BYTE.
- CMD: on spi_rx, latch addr=spi_rx_byte[AW-1:0].
  - spi_rx_byte[7]=1 -> RD_REQ.
  - spi_rx_byte[7]=0 -> WR.
- WR: on spi_rx at cycle t:
  - reg_we=1 at t+1, with reg_addr=current addr and reg_wdata=spi_rx_byte.
  - addr updates per the optional feature.
  - spi_tx_byte stays IDLE_BYTE.
- RD_REQ: reg_re=1 for one cycle with reg_addr=addr. reg_rdata is captured into spi_tx_byte in the following cycle. Then -> RD.
- RD: each spi_rx (end of a data byte) advances addr per the optional feature and re-enters RD_REQ to prefetch the next byte.
- Latency: spi_rx at cycle t -> reg_re at t+1 -> spi_tx_byte valid at t+3.
  - spi_tx of the next byte arrives one SPI half-period after spi_rx.
  - The SPI clock half-period must therefore be ≥ 4 clk cycles; this is the system requirement.
- spi_tx is informational only. The controller never changes spi_tx_byte in the cycle spi_tx is high; any pending update is deferred by one cycle.
- spi_ss=1 in any non-IDLE state:
  - Next cycle: state=IDLE, spi_tx_byte=IDLE_BYTE, frame_done=1 for one cycle.
  - A pending reg_we or reg_re scheduled for that same cycle still issues, because it belongs to a byte that completed.
  - A partial byte produces no pulse.
- spi_ss=1 in CMD before any byte is received: frame_done still pulses, with no bus activity.
- Simultaneous spi_rx and spi_ss=1 in the same cycle: the byte is processed (write committed / read issued), then the FSM goes to IDLE.
- Address arithmetic: AW-bit, wraps from 2^AW-1 to 0 with no error.
- Bursts are unbounded.

Optional Feature:
- Macro SPI_REG_CTRL_AUTOINC_EN.
- Defined: addr increments by 1 (mod 2^AW) after each data byte, in both WR and RD.
- Undefined: addr stays fixed at the command address for the whole frame (FIFO-style register access), and the increment logic is not synthesised.

Test Plan:
- Write burst: cmd 8'h05, data 8'h11, 8'h22 ->
  - With AUTOINC: reg_we pulses (addr 5, 8'h11) and (addr 6, 8'h22).
  - Without AUTOINC: both pulses go to addr 5.
  - MISO shows 8'hFF on every byte.
- Read burst: cmd 8'h83, reg model returns addr^8'h5A, SPI half-period 4 clk ->
  - MISO bytes: 8'hFF, 8'h59, 8'h5E (AUTOINC).
  - reg_re pulses at addrs 3, 4, 5; the final prefetch of addr 5 is discarded.
- Wrap: cmd 8'h7F (write), 3 data bytes -> writes at addrs 127, 0, 1.
- Abort: raise spi_ss after 4 bits of the first write data byte -> no reg_we, frame_done=1 once, busy=0 next cycle.
- Async reset asserted mid-read burst -> all outputs at reset values immediately; the next frame with cmd 8'h80 reads addr 0 correctly.
- ena=0 held across an spi_rx strobe -> strobe ignored, no reg_we; behaviour resumes on later strobes once ena=1.
